// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: shared definitions for the registered immediate extender.
//   - default widths for the immediate, the extended result and the sideband tag
//   - width of the accepted-transaction counter
//   - extension mode encodings (mode_e)
package imm_ext_pkg;

  localparam int unsigned DATA_IN_W  = 16;
  localparam int unsigned DATA_OUT_W = 32;
  localparam int unsigned TAG_W_DEF  = 5;
  localparam int unsigned CNT_W      = 32;

  typedef enum logic [1:0] {
    MODE_SEXT   = 2'b00,
    MODE_ZEXT   = 2'b01,
    MODE_LUI    = 2'b10,
    MODE_BRANCH = 2'b11
  } mode_e;

endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core: combinational mode mux and immediate extension.
// Ports:
//   imm   in  DATA_IN   immediate field
//   mode  in  2         extension mode (mode_e encoding)
//   ext_c out DATA_OUT  extended result (combinational)
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned DATA_IN  = DATA_IN_W,
  parameter int unsigned DATA_OUT = DATA_OUT_W
) (
  input  logic [DATA_IN-1:0]  imm,
  input  logic [1:0]          mode,
  output logic [DATA_OUT-1:0] ext_c
);

  localparam int unsigned PAD = DATA_OUT - DATA_IN;

  logic [DATA_OUT-1:0] sext;
  logic [DATA_OUT-1:0] zext;
  logic [DATA_OUT-1:0] lui;

  assign sext = {{PAD{imm[DATA_IN-1]}}, imm};
  assign zext = {{PAD{1'b0}}, imm};
  assign lui  = {imm, {PAD{1'b0}}};

  // Mode select; branch offset drops the two top sign bits after the shift.
  always_comb begin
    ext_c = sext;
    case (mode_e'(mode))
      MODE_SEXT:   ext_c = sext;
      MODE_ZEXT:   ext_c = zext;
      MODE_LUI:    ext_c = lui;
      MODE_BRANCH: ext_c = sext << 2;
      default:     ext_c = sext;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered immediate extender with valid/ready handshake
// and a 2-entry (head + skid) buffer, for the decode -> execute boundary.
// Optional feature macro: IMM_EXT_XFER_CNT_EN (accepted-transaction counter).
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   synchronous active-high reset
//   FLUSH      in   synchronous squash of all buffered entries
//   IN_VALID   in   upstream offers an immediate
//   IN_READY   out  block can accept (registered, = !skid valid)
//   IN         in   immediate field, DATA_IN bits
//   MODE       in   00 SEXT, 01 ZEXT, 10 LUI, 11 BRANCH
//   TAG_IN     in   sideband tag
//   OUT_VALID  out  OUT holds a valid result
//   OUT_READY  in   downstream accepts
//   OUT        out  extended result, DATA_OUT bits
//   TAG_OUT    out  tag matching OUT
//   XFER_CNT   out  accepted-transaction count (0 when feature disabled)
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned DATA_IN  = DATA_IN_W,
  parameter int unsigned DATA_OUT = DATA_OUT_W,
  parameter int unsigned TAG_W    = TAG_W_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                FLUSH,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [DATA_IN-1:0]  IN,
  input  logic [1:0]          MODE,
  input  logic [TAG_W-1:0]    TAG_IN,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [DATA_OUT-1:0] OUT,
  output logic [TAG_W-1:0]    TAG_OUT,
  output logic [CNT_W-1:0]    XFER_CNT
);

  logic [DATA_OUT-1:0] ext_c;

  logic                head_valid_q, head_valid_d;
  logic [DATA_OUT-1:0] head_data_q,  head_data_d;
  logic [TAG_W-1:0]    head_tag_q,   head_tag_d;
  logic                skid_valid_q, skid_valid_d;
  logic [DATA_OUT-1:0] skid_data_q,  skid_data_d;
  logic [TAG_W-1:0]    skid_tag_q,   skid_tag_d;
  logic                in_ready_q,   in_ready_d;

  logic accept_c;
  logic drain_c;

  imm_ext_core #(
    .DATA_IN  (DATA_IN),
    .DATA_OUT (DATA_OUT)
  ) u_core (
    .imm   (IN),
    .mode  (MODE),
    .ext_c (ext_c)
  );

  // An input offered during a flush is dropped, so it is not an accept.
  assign accept_c = IN_VALID && in_ready_q && !FLUSH;
  assign drain_c  = head_valid_q && OUT_READY;

  // Head/skid next state: head refills from skid first to keep FIFO order.
  always_comb begin
    head_valid_d = head_valid_q;
    head_data_d  = head_data_q;
    head_tag_d   = head_tag_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_tag_d   = skid_tag_q;

    if (FLUSH) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!head_valid_q || drain_c) begin
      if (skid_valid_q) begin
        head_valid_d = 1'b1;
        head_data_d  = skid_data_q;
        head_tag_d   = skid_tag_q;
        skid_valid_d = accept_c;
        if (accept_c) begin
          skid_data_d = ext_c;
          skid_tag_d  = TAG_IN;
        end
      end else begin
        head_valid_d = accept_c;
        if (accept_c) begin
          head_data_d = ext_c;
          head_tag_d  = TAG_IN;
        end
      end
    end else if (accept_c) begin
      skid_valid_d = 1'b1;
      skid_data_d  = ext_c;
      skid_tag_d   = TAG_IN;
    end

    in_ready_d = !skid_valid_d;
  end

  // Buffer state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
      head_tag_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_tag_q   <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
      head_tag_q   <= head_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_tag_q   <= skid_tag_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign OUT_VALID = head_valid_q;
  assign OUT       = head_data_q;
  assign TAG_OUT   = head_tag_q;
  assign IN_READY  = in_ready_q;

`ifdef IMM_EXT_XFER_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Accept counter; wraps naturally, ignores FLUSH.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (accept_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign XFER_CNT = cnt_q;
`else
  assign XFER_CNT = '0;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed self-checking bench for imm_extend_pipe
// (default widths 16/32/5). Works with or without IMM_EXT_XFER_CNT_EN.
module tb_imm_extend_pipe;

`ifdef IMM_EXT_XFER_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  mode;
  logic [4:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  tag_out;
  logic [31:0] xfer_cnt;

  int total;
  int bad;
  int exp_cnt;

  imm_extend_pipe dut (
    .CLK       (clk),
    .RST       (rst),
    .FLUSH     (flush),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .IN        (in_data),
    .MODE      (mode),
    .TAG_IN    (tag_in),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .OUT       (out_data),
    .TAG_OUT   (tag_out),
    .XFER_CNT  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [15:0] d, input logic [1:0] m, input logic [4:0] t);
    in_valid = 1'b1;
    in_data  = d;
    mode     = m;
    tag_in   = t;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset out got=%h want=0", out_data); end
    total++; if (tag_out !== 5'd0) begin bad++; $display("FAIL reset tag_out got=%0d want=0", tag_out); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready got=%b want=1", in_ready); end
    total++; if (xfer_cnt !== 32'd0) begin bad++; $display("FAIL reset xfer_cnt got=%0d want=0", xfer_cnt); end
    rst = 1'b0;
    exp_cnt = 0;
    tick();
  endtask

  task automatic test_sext_zext();
    out_ready = 1'b1;
    offer(16'h8004, 2'b00, 5'd1);
    tick();
    exp_cnt++;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sext out_valid got=%b want=1", out_valid); end
    total++; if (out_data !== 32'hFFFF8004) begin bad++; $display("FAIL sext out got=%h want=ffff8004", out_data); end
    total++; if (tag_out !== 5'd1) begin bad++; $display("FAIL sext tag got=%0d want=1", tag_out); end
    offer(16'h8004, 2'b01, 5'd2);
    tick();
    exp_cnt++;
    in_valid = 1'b0;
    total++; if (out_data !== 32'h00008004) begin bad++; $display("FAIL zext out got=%h want=00008004", out_data); end
    total++; if (tag_out !== 5'd2) begin bad++; $display("FAIL zext tag got=%0d want=2", tag_out); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL empty out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 32'h00008004) begin bad++; $display("FAIL empty keeps out got=%h want=00008004", out_data); end
  endtask

  task automatic test_lui_branch();
    out_ready = 1'b1;
    offer(16'h1234, 2'b10, 5'd3);
    tick();
    exp_cnt++;
    total++; if (out_data !== 32'h12340000) begin bad++; $display("FAIL lui out got=%h want=12340000", out_data); end
    offer(16'hFFFF, 2'b11, 5'd4);
    tick();
    exp_cnt++;
    total++; if (out_data !== 32'hFFFFFFFC) begin bad++; $display("FAIL branch_neg out got=%h want=fffffffc", out_data); end
    offer(16'h7FFF, 2'b11, 5'd5);
    tick();
    exp_cnt++;
    in_valid = 1'b0;
    total++; if (out_data !== 32'h0001FFFC) begin bad++; $display("FAIL branch_pos out got=%h want=0001fffc", out_data); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL branch_pos out_valid got=%b want=1", out_valid); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    offer(16'd1, 2'b00, 5'd1);
    tick();
    exp_cnt++;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp1 in_ready got=%b want=1", in_ready); end
    offer(16'd2, 2'b00, 5'd2);
    tick();
    exp_cnt++;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full in_ready got=%b want=0", in_ready); end
    // Item 3 held upstream while full; MODE changes must not affect held items.
    offer(16'd3, 2'b10, 5'd3);
    tick();
    total++; if (tag_out !== 5'd1) begin bad++; $display("FAIL bp_hold tag got=%0d want=1", tag_out); end
    total++; if (out_data !== 32'd1) begin bad++; $display("FAIL bp_hold out got=%h want=1", out_data); end
    offer(16'd3, 2'b00, 5'd3);
    out_ready = 1'b1;
    tick();
    total++; if (tag_out !== 5'd2 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_tag2 tag got=%0d/%b want=2/1", tag_out, out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b want=1", in_ready); end
    tick();
    exp_cnt++;
    in_valid = 1'b0;
    total++; if (tag_out !== 5'd3 || out_data !== 32'd3) begin bad++; $display("FAIL bp_tag3 tag got=%0d out=%h want=3/3", tag_out, out_data); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained out_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    offer(16'd4, 2'b00, 5'd4);
    tick();
    offer(16'd5, 2'b00, 5'd5);
    tick();
    exp_cnt += 2;
    offer(16'd6, 2'b00, 5'd6);
    flush = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_full out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_full in_ready got=%b want=1", in_ready); end
    total++; if (out_data !== 32'd4) begin bad++; $display("FAIL flush keeps out got=%h want=4", out_data); end
    // Offer while ready during flush: dropped and not counted.
    offer(16'd7, 2'b00, 5'd7);
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_drop out_valid got=%b want=0", out_valid); end
    total++; if (xfer_cnt !== (CNT_EN ? 32'(exp_cnt) : 32'd0)) begin bad++; $display("FAIL flush xfer_cnt got=%0d want=%0d", xfer_cnt, CNT_EN ? exp_cnt : 0); end
    flush = 1'b0;
    out_ready = 1'b1;
    offer(16'd8, 2'b00, 5'd8);
    tick();
    exp_cnt++;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || tag_out !== 5'd8) begin bad++; $display("FAIL flush_recover got=%b/%0d want=1/8", out_valid, tag_out); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      logic [15:0] v;
      v = 16'(i + 16'h100);
      offer(v, 2'b01, 5'(i));
      tick();
      exp_cnt++;
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== {16'h0, v}) begin
        bad++; $display("FAIL b2b[%0d] rdy=%b vld=%b out=%h want 1/1/%h", i, in_ready, out_valid, out_data, {16'h0, v});
      end
    end
    in_valid = 1'b0;
    tick();
    total++; if (xfer_cnt !== (CNT_EN ? 32'(exp_cnt) : 32'd0)) begin bad++; $display("FAIL counter xfer_cnt got=%0d want=%0d", xfer_cnt, CNT_EN ? exp_cnt : 0); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    offer(16'd9, 2'b00, 5'd9);
    tick();
    offer(16'd10, 2'b00, 5'd10);
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_mid pre full in_ready got=%b want=0", in_ready); end
    rst = 1'b1;
    out_ready = 1'b1;
    offer(16'd11, 2'b00, 5'd11);
    tick();
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_mid out got=%h want=0", out_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid in_ready got=%b want=1", in_ready); end
    total++; if (xfer_cnt !== 32'd0) begin bad++; $display("FAIL rst_mid xfer_cnt got=%0d want=0", xfer_cnt); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid after out_valid got=%b want=0", out_valid); end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    exp_cnt   = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    mode      = 2'b00;
    tag_in    = '0;
    out_ready = 1'b0;
    test_reset();
    test_sext_zext();
    test_lui_branch();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Parametrised, registered immediate-extension unit for the MIPS datapath. It is the next generation of the combinational sign extender.
- Four extension modes: sign, zero, upper-load (LUI), and branch offset (sign-extend then shift left 2).
- Valid/ready handshake on both sides, backed by a 2-entry skid buffer, so it can sit between the decode and execute stages of the pipelined core.

Parameters:
DATA_IN, 16, immediate field width; must be at least 2.
DATA_OUT, 32, extended output width; must be greater than DATA_IN + 1.
TAG_W, 5, width of the sideband tag (destination register index) carried alongside the data.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RST  input  1  synchronous, active-high reset.
FLUSH  input  1  synchronous clear of all buffered entries (branch/jump squash).
IN_VALID  input  1  upstream offers an immediate.
IN_READY  output  1  block can accept; registered.
IN  input  DATA_IN  immediate field.
MODE  input  2  00 SEXT, 01 ZEXT, 10 LUI, 11 BRANCH.
TAG_IN  input  TAG_W  sideband tag.
OUT_VALID  output  1  OUT holds a valid result.
OUT_READY  input  1  downstream accepts.
OUT  output  DATA_OUT  extended result.
TAG_OUT  output  TAG_W  tag matching OUT.
XFER_CNT  output  32  accepted-transaction count (see Optional Feature).

Behaviour:
- Reset (RST=1 at an edge): both entries invalid, OUT_VALID=0, OUT=0, TAG_OUT=0, IN_READY=1, XFER_CNT=0. Reset has priority over FLUSH and over any handshake.
- Extension arithmetic, computed on accept, unsigned widths:
  - SEXT: {(DATA_OUT-DATA_IN) copies of IN[DATA_IN-1], IN}.
  - ZEXT: {zeros, IN}.
  - LUI: IN << (DATA_OUT-DATA_IN), low bits zero.
  - BRANCH: SEXT result << 2, truncated to DATA_OUT.
- Input accept: IN_VALID && IN_READY at an edge.
- Output transfer: OUT_VALID && OUT_READY at an edge.
- Latency: 1 cycle. An item accepted at edge N is on OUT with OUT_VALID=1 after edge N, provided the output register is empty or drains at edge N.
- Storage: output register (head) plus one skid register.
  - Head empty, or draining this edge: new item goes to head.
  - Head held (valid and not draining): new item goes to skid.
  - Head drains while skid is full: skid moves to head. A simultaneous accept then fills skid.
- IN_READY is registered and equals !skid_valid for the next cycle. Throughput is 1/cycle with OUT_READY=1. No item is lost or duplicated under any OUT_READY pattern.
- Full: head and skid both valid, so IN_READY=0 and IN_VALID is ignored.
- Empty: OUT_VALID=0. OUT keeps its last value; it is not cleared.
- FLUSH=1 at an edge:
  - Both entries are invalidated, OUT_VALID=0 and IN_READY=1 next cycle.
  - An input offered in the same cycle is dropped and not counted.
  - An output transfer in the same cycle still counts as delivered downstream.
- MODE is sampled only at accept. Changing MODE while an item is held has no effect on it.
- Ordering: strict FIFO.

Optional Feature:
Macro IMM_EXT_XFER_CNT_EN.
- Defined: XFER_CNT increments by 1 on every input accept. It wraps 0xFFFFFFFF to 0, clears on RST, and is unaffected by FLUSH.
- Not defined: XFER_CNT is tied to 0 and no counter flops are built.

Decomposition:
- Shared package imm_ext_pkg holds:
  - mode encodings MODE_SEXT=2'b00, MODE_ZEXT=2'b01, MODE_LUI=2'b10, MODE_BRANCH=2'b11;
  - default widths 16/32/5.
- One sub-module, imm_ext_core: purely combinational mode mux and extension, parameterised on DATA_IN/DATA_OUT. The top level holds the skid/handshake logic.

Test Plan:
- SEXT/ZEXT, DATA_IN=16, DATA_OUT=32, OUT_READY=1: IN=16'h8004 -> OUT=32'hFFFF8004 for SEXT and 32'h00008004 for ZEXT, each one cycle after accept.
- LUI and BRANCH: IN=16'h1234 LUI -> 32'h12340000. IN=16'hFFFF BRANCH -> 32'hFFFFFFFC. IN=16'h7FFF BRANCH -> 32'h0001FFFC.
- Backpressure: OUT_READY=0 and stream 3 items (tags 1, 2, 3). Two are accepted and IN_READY drops to 0; item 3 is held upstream. Release OUT_READY and check tags 1, 2, 3 emerge in order with no loss.
- Flush: head and skid full with IN_VALID=1 and FLUSH=1 -> next cycle OUT_VALID=0 and IN_READY=1. With the macro defined, XFER_CNT is unchanged by the dropped input.
- Reset mid-operation: assert RST while full and OUT_READY toggles -> OUT_VALID=0, OUT=0, IN_READY=1, XFER_CNT=0 on the next cycle.
- Counter: with IMM_EXT_XFER_CNT_EN defined, 100 back-to-back accepts -> XFER_CNT=100. Without the macro, XFER_CNT stays 0.
